heap_array_shifter: RTL and testbench

Multi-cycle engine that executes the shiftUp (insert at position) and shiftDown (remove at position) array instructions on one heap area. It sits downstream of the instruction executor, which hands it a command and stalls until the done pulse. It drives the heap memory port directly, moving one element per two cycles instead of copying a whole area through a shadow buffer in one step. Array sizes stay with the executor: size goes in with the command and the new size comes back on done.

---
 rtl/heap_pkg.sv | 23 ++
 rtl/heap_array_shifter.sv | 187 ++++++++++++++++++
 tb/tb_heap_array_shifter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/heap_pkg.sv
// Shared heap definitions: default geometry, shift op encoding
// and the shifter FSM states.
package heap_pkg;

   localparam int MEM_W    = 12;
   localparam int N_AREA   = 4;
   localparam int N_ARRAYS = 2;

   typedef enum logic {
      SHIFT_UP   = 1'b0,
      SHIFT_DOWN = 1'b1
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_INSERT,
      S_CLEAR,
      S_DONE
   } state_t;

endpackage

// File: rtl/heap_array_shifter.sv
// Multi-cycle insert/remove-at-position engine for one heap area,
// moving one element per read/write cycle pair.
module heap_array_shifter
   import heap_pkg::*;
#(
   parameter int MemoryElementWidth = MEM_W,
   parameter int NArea              = N_AREA,
   parameter int NArrays            = N_ARRAYS,
   parameter int AddrWidth          = $clog2(NArea * NArrays)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cmdValid,
   output logic                          cmdReady,
   input  logic                          cmdOp,
   input  logic [MemoryElementWidth-1:0] cmdArray,
   input  logic [MemoryElementWidth-1:0] cmdPos,
   input  logic [MemoryElementWidth-1:0] cmdValue,
   input  logic [MemoryElementWidth-1:0] cmdSize,
   output logic                          done,
   output logic                          doneError,
   output logic [MemoryElementWidth-1:0] doneSize,
   output logic [MemoryElementWidth-1:0] doneValue,
   output logic [AddrWidth-1:0]          memAddr,
   output logic                          memRe,
   input  logic [MemoryElementWidth-1:0] memRdata,
   output logic                          memWe,
   output logic [MemoryElementWidth-1:0] memWdata
);

   localparam int MW = MemoryElementWidth;
   localparam int PW = (NArea > 1) ? $clog2(NArea) : 1;
   localparam logic [MW-1:0] AREA   = MW'(NArea);
   localparam logic [MW-1:0] ARRAYS = MW'(NArrays);
   localparam logic [MW-1:0] ONE    = MW'(1);
   localparam logic [PW-1:0] STEP   = PW'(1);

   state_t state, state_d;
   op_t    op_q, op_d;

   logic [AddrWidth-1:0] base_q, base_d;
   logic [PW-1:0] cur_q, cur_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [PW-1:0] last_q, last_d;
   logic [PW-1:0] dec, inc, off;
   logic [MW-1:0] val_q, val_d;
   logic [MW-1:0] size_q, size_d;
   logic [MW-1:0] dval_q, dval_d;
   logic err_q, err_d;
   logic first_q, first_d;
   logic cap_q, cap_d;
   logic bad_up, bad_down, bad_cmd;

   // size is range-checked before pos, so size+1 never wraps
   assign bad_up   = (cmdSize >= AREA) || (cmdPos > cmdSize);
   assign bad_down = (cmdSize == '0) || (cmdPos >= cmdSize);
   assign bad_cmd  = (cmdArray >= ARRAYS)
                   || (cmdOp ? bad_down : bad_up);

   assign dec = cur_q - STEP;
   assign inc = cur_q + STEP;

   assign cmdReady  = (state == S_IDLE);
   assign done      = (state == S_DONE);
   assign doneError = done && err_q;
   assign doneSize  = size_q;
   assign doneValue = dval_q;

   always_comb begin
      state_d  = state;
      op_d     = op_q;
      base_d   = base_q;
      cur_d    = cur_q;
      pos_d    = pos_q;
      last_d   = last_q;
      val_d    = val_q;
      size_d   = size_q;
      err_d    = err_q;
      first_d  = first_q;
      cap_d    = (state == S_READ) && first_q;
      dval_d   = cap_q ? memRdata : dval_q;
      memRe    = 1'b0;
      memWe    = 1'b0;
      memWdata = '0;
      off      = cur_q;

      unique case (state)
         S_IDLE: begin
            if (cmdValid) begin
               op_d    = op_t'(cmdOp);
               base_d  = AddrWidth'(cmdArray * AREA);
               val_d   = cmdValue;
               dval_d  = '0;
               err_d   = bad_cmd;
               first_d = 1'b0;
               if (bad_cmd) begin
                  size_d  = cmdSize;
                  state_d = S_DONE;
               end else if (op_t'(cmdOp) == SHIFT_UP) begin
                  size_d  = cmdSize + ONE;
                  cur_d   = PW'(cmdSize);
                  pos_d   = PW'(cmdPos);
                  state_d = (cmdSize > cmdPos) ? S_READ : S_INSERT;
               end else begin
                  size_d  = cmdSize - ONE;
                  cur_d   = PW'(cmdPos);
                  last_d  = PW'(cmdSize - ONE);
                  first_d = 1'b1;
                  state_d = S_READ;
               end
            end
         end
         S_READ: begin
            memRe = 1'b1;
            if (op_q == SHIFT_UP) begin
               off     = dec;
               state_d = S_WRITE;
            end else if (first_q) begin
               // fetch of the removed element, not a move
               off     = cur_q;
               first_d = 1'b0;
               state_d = (cur_q < last_q) ? S_READ : S_CLEAR;
            end else begin
               off     = inc;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            memWe    = 1'b1;
            memWdata = memRdata;
            if (op_q == SHIFT_UP) begin
               cur_d   = dec;
               state_d = (dec > pos_q) ? S_READ : S_INSERT;
            end else begin
               cur_d   = inc;
               state_d = (inc < last_q) ? S_READ : S_CLEAR;
            end
         end
         S_INSERT: begin
            memWe    = 1'b1;
            memWdata = val_q;
            off      = pos_q;
            state_d  = S_DONE;
         end
         S_CLEAR: begin
            memWe   = 1'b1;
            off     = last_q;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      memAddr = (memRe || memWe) ? base_q + AddrWidth'(off) : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         op_q    <= SHIFT_UP;
         base_q  <= '0;
         cur_q   <= '0;
         pos_q   <= '0;
         last_q  <= '0;
         val_q   <= '0;
         size_q  <= '0;
         dval_q  <= '0;
         err_q   <= 1'b0;
         first_q <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state   <= state_d;
         op_q    <= op_d;
         base_q  <= base_d;
         cur_q   <= cur_d;
         pos_q   <= pos_d;
         last_q  <= last_d;
         val_q   <= val_d;
         size_q  <= size_d;
         dval_q  <= dval_d;
         err_q   <= err_d;
         first_q <= first_d;
         cap_q   <= cap_d;
      end
   end

endmodule

// File: tb/tb_heap_array_shifter.sv
// Bench for heap_array_shifter: vector table plus scoreboard,
// with a 1-cycle-latency heap memory model.
module tb_heap_array_shifter;
   import heap_pkg::*;

   localparam int W = 12;

   typedef struct {
      logic op;
      int   arr, pos, val, size;
      logic err;
      int   nsize, dval, lat, strobes;
      logic [0:3][W-1:0] area;
   } vec_t;

   typedef struct {
      logic err;
      int   nsize, dval, lat, strobes;
      logic [0:7][W-1:0] heap;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cmdValid = 1'b0;
   logic cmdReady;
   logic cmdOp = 1'b0;
   logic [W-1:0] cmdArray = '0, cmdPos = '0;
   logic [W-1:0] cmdValue = '0, cmdSize = '0;
   logic done, doneError;
   logic [W-1:0] doneSize, doneValue;
   logic [2:0] memAddr;
   logic memRe, memWe;
   logic [W-1:0] memRdata = '0, memWdata;

   logic [W-1:0] mem [0:7];
   logic ld_en = 1'b0;
   logic [2:0] ld_addr = '0;
   logic [W-1:0] ld_data = '0;

   logic [0:7][W-1:0] mh = '0;
   exp_t exp_q[$];
   int   acc_q[$];
   int   snap_q[$];
   vec_t vt[10];

   int total = 0, bad = 0;
   int cyc = 0, strobes = 0, viol = 0, cur_base = 0;

   heap_array_shifter dut (
      .clock(clock), .reset(reset),
      .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdOp(cmdOp), .cmdArray(cmdArray),
      .cmdPos(cmdPos), .cmdValue(cmdValue),
      .cmdSize(cmdSize),
      .done(done), .doneError(doneError),
      .doneSize(doneSize), .doneValue(doneValue),
      .memAddr(memAddr), .memRe(memRe),
      .memRdata(memRdata), .memWe(memWe),
      .memWdata(memWdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (memWe) mem[memAddr] <= memWdata;
      if (memRe) memRdata <= mem[memAddr];
   end

   function automatic void chk(string n, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", n, act, exp);
      end
   endfunction

   always @(posedge clock) begin
      if (reset && cmdValid && cmdReady) begin
         acc_q.push_back(cyc + 1);
         snap_q.push_back(strobes);
         cur_base <= int'(cmdArray) * 4;
      end
   end

   always @(negedge clock) begin
      exp_t e;
      int a, s;
      if (memRe || memWe) begin
         strobes <= strobes + 1;
         viol <= viol + int'(memRe && memWe)
               + int'(int'(memAddr) < cur_base
                      || int'(memAddr) > cur_base + 3);
      end
      if (done) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            s = snap_q.pop_front();
            chk("doneError", int'(doneError), int'(e.err));
            chk("doneSize", int'(doneSize), e.nsize);
            chk("doneValue", int'(doneValue), e.dval);
            chk("latency", cyc - a + 1, e.lat);
            chk("mem_cycles", strobes - s, e.strobes);
            for (int k = 0; k < 8; k++)
               chk($sformatf("heap[%0d]", k),
                   int'(mem[k]), int'(e.heap[k]));
         end
      end
   end

   function automatic vec_t mk(
      logic op, int arr, int pos, int val, int size,
      logic err, int nsize, int dval, int lat, int str,
      int a0, int a1, int a2, int a3);
      vec_t v;
      v.op = op; v.arr = arr; v.pos = pos;
      v.val = val; v.size = size; v.err = err;
      v.nsize = nsize; v.dval = dval;
      v.lat = lat; v.strobes = str;
      v.area[0] = W'(a0); v.area[1] = W'(a1);
      v.area[2] = W'(a2); v.area[3] = W'(a3);
      return v;
   endfunction

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.err = v.err; e.nsize = v.nsize;
      e.dval = v.dval; e.lat = v.lat;
      e.strobes = v.strobes;
      e.heap = mh;
      if (!v.err)
         for (int k = 0; k < 4; k++)
            e.heap[v.arr * 4 + k] = v.area[k];
      mh = e.heap;
      exp_q.push_back(e);
   endtask

   task automatic issue(input vec_t v, input bit push);
      int k = 0;
      if (push) push_exp(v);
      cmdOp = v.op;
      cmdArray = W'(v.arr);
      cmdPos = W'(v.pos);
      cmdValue = W'(v.val);
      cmdSize = W'(v.size);
      cmdValid = 1'b1;
      while (!cmdReady && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk("accept_ready", int'(cmdReady), 1);
      @(posedge clock); #1;
      cmdValid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk("pending_results", exp_q.size(), 0);
      if (exp_q.size() != 0) begin
         exp_q.delete();
         acc_q.delete();
         snap_q.delete();
      end
   endtask

   task automatic load(input int arr, input logic [0:3][W-1:0] a);
      for (int k = 0; k < 4; k++) begin
         ld_en = 1'b1;
         ld_addr = 3'(arr * 4 + k);
         ld_data = a[k];
         mh[arr * 4 + k] = a[k];
         @(posedge clock); #1;
      end
      ld_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va, vb, vc;
      vt[0] = mk(SHIFT_UP,   1, 0, 99, 3, 0, 4,  0, 8, 7, 99, 0, 1, 2);
      vt[1] = mk(SHIFT_DOWN, 1, 0,  0, 4, 0, 3, 99, 9, 8,  0, 1, 2, 0);
      vt[2] = mk(SHIFT_UP,   1, 0, 11, 4, 1, 4,  0, 1, 0,  0, 0, 0, 0);
      vt[3] = mk(SHIFT_DOWN, 1, 0,  0, 0, 1, 0,  0, 1, 0,  0, 0, 0, 0);
      vt[4] = mk(SHIFT_UP,   1, 3, 11, 2, 1, 2,  0, 1, 0,  0, 0, 0, 0);
      vt[5] = mk(SHIFT_UP,   0, 2,  7, 2, 0, 3,  0, 2, 1,  5, 6, 7, 0);
      vt[6] = mk(SHIFT_UP,   2, 0, 11, 0, 1, 0,  0, 1, 0,  0, 0, 0, 0);
      vt[7] = mk(SHIFT_DOWN, 0, 1,  0, 3, 0, 2,  6, 5, 4,  5, 7, 0, 0);
      vt[8] = mk(SHIFT_DOWN, 0, 1,  0, 2, 0, 1,  7, 3, 2,  5, 0, 0, 0);
      vt[9] = mk(SHIFT_UP,   0, 0,  3, 1, 0, 2,  0, 4, 3,  3, 5, 0, 0);
      va = mk(SHIFT_UP,   1, 1, 50, 3, 0, 4, 0, 6, 5, 0, 50, 1, 2);
      vb = mk(SHIFT_DOWN, 1, 3,  0, 4, 0, 3, 2, 3, 2, 0, 50, 1, 0);
      vc = mk(SHIFT_UP,   0, 0,  9, 2, 0, 3, 0, 6, 5, 9, 3, 5, 0);

      #2 reset = 1'b0;
      load(0, {12'd5, 12'd6, 12'd0, 12'd0});
      load(1, {12'd0, 12'd1, 12'd2, 12'd0});
      chk("rst_cmdReady", int'(cmdReady), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_doneError", int'(doneError), 0);
      chk("rst_memRe", int'(memRe), 0);
      chk("rst_memWe", int'(memWe), 0);
      chk("rst_doneSize", int'(doneSize), 0);
      chk("rst_doneValue", int'(doneValue), 0);
      chk("rst_memAddr", int'(memAddr), 0);
      chk("rst_memWdata", int'(memWdata), 0);
      reset = 1'b1;
      @(posedge clock); #1;

      for (int i = 0; i < 10; i++) begin
         issue(vt[i], 1'b1);
         drain();
      end

      issue(va, 1'b1);
      chk("busy_cmdReady", int'(cmdReady), 0);
      issue(vb, 1'b1);
      drain();

      issue(vc, 1'b0);
      @(posedge clock);
      @(posedge clock); #1;
      chk("pre_reset_memRe", int'(memRe), 1);
      reset = 1'b0;
      #1;
      chk("abort_memRe", int'(memRe), 0);
      chk("abort_memWe", int'(memWe), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_cmdReady", int'(cmdReady), 1);
      @(posedge clock);
      @(posedge clock); #1;
      reset = 1'b1;
      acc_q.delete();
      snap_q.delete();
      load(0, {12'd3, 12'd5, 12'd0, 12'd0});
      issue(vc, 1'b1);
      drain();

      repeat (3) @(posedge clock);
      #1;
      chk("strobe_rule_violations", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
